// File: rtl/fpu_defs.sv
// Shared FPU definitions: opcodes, IEEE-754 single field widths, operand classes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fpu_defs;

    localparam logic [2:0]  FPU_ADD   = 3'b000;
    localparam logic [2:0]  FPU_SUB   = 3'b001;
    localparam logic [2:0]  FPU_MUL   = 3'b010;
    localparam logic [2:0]  FPU_DIV   = 3'b011;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fpu_cls_t;

    // Leading-zero count of a 27-bit value; 27 when the value is zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fpu_classify.sv
// Splits a single-precision operand into sign/exponent/mantissa and classifies it.
// Latency: combinational.
// Backpressure: none.
// Ports: operand (in), sign/exp/man (man carries the hidden bit, zeroed for flushed values), cls.
module fpu_classify
    import fpu_defs::*;
(
    input  logic [31:0]      operand,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W:0]   man,
    output fpu_cls_t         cls
);

    logic [MAN_W-1:0] frac;

    always_comb begin
        sign = operand[31];
        exp  = operand[30:23];
        frac = operand[22:0];
        man  = {1'b1, frac};
        cls  = CLS_NORM;
        if (exp == '0) begin
            // Subnormals are flushed: treated as a zero of the same sign.
            cls = CLS_ZERO;
            man = '0;
        end else if (exp == '1) begin
            cls = (frac != '0) ? CLS_NAN : CLS_INF;
        end
    end

endmodule

// File: rtl/fpu_iter_exec.sv
// Multi-cycle single-precision add/sub/mul/div, round-toward-zero, flush-to-zero.
// Latency: done at cycle 2 (special/invalid), 4 (add/sub), 27 (mul), 28 (div) after accept.
// Backpressure: start is only sampled in IDLE; requests while busy or in DONE are dropped.
// Ports: CLK, RST (sync, active-high), start, FPUControl, SrcA, SrcB ->
//        busy, done, FPUResult, flag_invalid, flag_divzero (result/flags held until next done).
module fpu_iter_exec
    import fpu_defs::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [2:0]  FPUControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        busy,
    output logic        done,
    output logic [31:0] FPUResult,
    output logic        flag_invalid,
    output logic        flag_divzero
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_ALIGN  = 3'd2;
    localparam logic [2:0] S_MUL    = 3'd3;
    localparam logic [2:0] S_DIV    = 3'd4;
    localparam logic [2:0] S_NORM   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [30:0] INF_MAG = 31'h7F80_0000;
    localparam logic [30:0] MAX_MAG = 31'h7F7F_FFFF;

    logic [2:0]  state;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W:0]   ma, mb;
    fpu_cls_t         ca, cb;

    fpu_classify u_cls_a (.operand(a_q), .sign(sa), .exp(ea), .man(ma), .cls(ca));
    fpu_classify u_cls_b (.operand(b_q), .sign(sb), .exp(eb), .man(mb), .cls(cb));

    // Working datapath state
    logic               sign_r, eff_sub;
    logic signed [9:0]  exp_r;
    logic [26:0]        man_big, man_small;   // 24-bit mantissa + guard/round/sticky
    logic [47:0]        prod;                 // upper: partial sum, lower: remaining multiplier bits
    logic [24:0]        rem, quo;
    logic [4:0]         cnt;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Effective sign of B once subtraction is folded in.
    logic sb_eff;
    assign sb_eff = sb ^ (op_q == FPU_SUB);

    // Special-case detection, evaluated in UNPACK on the latched operands.
    logic        spec_hit, spec_nv, spec_dz;
    logic [31:0] spec_res;
    logic        sgn_md;

    always_comb begin
        spec_hit = 1'b0;
        spec_nv  = 1'b0;
        spec_dz  = 1'b0;
        spec_res = '0;
        sgn_md   = sa ^ sb;
        if (op_q[2] || ca == CLS_NAN || cb == CLS_NAN) begin
            spec_hit = 1'b1; spec_nv = 1'b1; spec_res = CANON_NAN;
        end else begin
            case (op_q)
                FPU_ADD, FPU_SUB: begin
                    spec_hit = 1'b1;
                    if (ca == CLS_INF && cb == CLS_INF) begin
                        if (sa != sb_eff) begin
                            spec_nv = 1'b1; spec_res = CANON_NAN;
                        end else begin
                            spec_res = {sa, INF_MAG};
                        end
                    end else if (ca == CLS_INF) spec_res = {sa, INF_MAG};
                    else if (cb == CLS_INF)     spec_res = {sb_eff, INF_MAG};
                    else if (ca == CLS_ZERO && cb == CLS_ZERO) spec_res = {sa & sb_eff, 31'b0};
                    else if (ca == CLS_ZERO)    spec_res = {sb_eff, b_q[30:0]};
                    else if (cb == CLS_ZERO)    spec_res = {sa, a_q[30:0]};
                    else                        spec_hit = 1'b0;
                end
                FPU_MUL: begin
                    spec_hit = 1'b1;
                    if ((ca == CLS_ZERO && cb == CLS_INF) || (ca == CLS_INF && cb == CLS_ZERO)) begin
                        spec_nv = 1'b1; spec_res = CANON_NAN;
                    end else if (ca == CLS_INF || cb == CLS_INF)   spec_res = {sgn_md, INF_MAG};
                    else if (ca == CLS_ZERO || cb == CLS_ZERO)     spec_res = {sgn_md, 31'b0};
                    else                                           spec_hit = 1'b0;
                end
                default: begin  // FPU_DIV
                    spec_hit = 1'b1;
                    if ((ca == CLS_ZERO && cb == CLS_ZERO) || (ca == CLS_INF && cb == CLS_INF)) begin
                        spec_nv = 1'b1; spec_res = CANON_NAN;
                    end else if (ca == CLS_INF)  spec_res = {sgn_md, INF_MAG};
                    else if (cb == CLS_INF)      spec_res = {sgn_md, 31'b0};
                    else if (cb == CLS_ZERO) begin
                        spec_dz = 1'b1; spec_res = {sgn_md, INF_MAG};
                    end else if (ca == CLS_ZERO) spec_res = {sgn_md, 31'b0};
                    else                         spec_hit = 1'b0;
                end
            endcase
        end
    end

    // Alignment: both operands are normal here, so raw magnitude bits order correctly.
    logic        a_big, small_stk;
    logic [7:0]  e_diff;
    logic [4:0]  shamt;
    logic [26:0] small_ext, small_sh;

    always_comb begin
        a_big     = (a_q[30:0] >= b_q[30:0]);
        e_diff    = a_big ? (ea - eb) : (eb - ea);
        shamt     = (e_diff > 8'd27) ? 5'd27 : e_diff[4:0];
        small_ext = {(a_big ? mb : ma), 3'b000};
        small_sh  = small_ext >> shamt;
        small_stk = ((small_sh << shamt) != small_ext);
    end

    // One shift-add step and one restoring-division step.
    logic [24:0] mul_sum, div_diff;
    logic        div_ge;

    always_comb begin
        mul_sum  = {1'b0, prod[47:24]} + (prod[0] ? {1'b0, mb} : 25'd0);
        div_ge   = (rem >= {1'b0, mb});
        div_diff = div_ge ? (rem - {1'b0, mb}) : rem;
    end

    // Normalise, truncate and pack.  Under RTZ the bits below the kept
    // fraction (including any division remainder) never change the result.
    logic [27:0]        sum;
    logic [26:0]        norm;
    logic [4:0]         lz;
    logic signed [9:0]  e_res;
    logic [MAN_W-1:0]   frac;
    logic               add_zero;
    logic [31:0]        norm_res;

    always_comb begin
        sum      = eff_sub ? ({1'b0, man_big} - {1'b0, man_small})
                           : ({1'b0, man_big} + {1'b0, man_small});
        norm     = '0;
        lz       = '0;
        e_res    = exp_r;
        frac     = '0;
        add_zero = 1'b0;
        case (op_q)
            FPU_MUL: begin
                if (prod[47]) begin
                    frac  = prod[46:24];
                    e_res = exp_r + 10'sd1;
                end else begin
                    frac  = prod[45:23];
                end
            end
            FPU_DIV: begin
                if (quo[24]) begin
                    frac  = quo[23:1];
                end else begin
                    frac  = quo[22:0];
                    e_res = exp_r - 10'sd1;
                end
            end
            default: begin
                if (sum == '0) begin
                    add_zero = 1'b1;
                end else if (sum[27]) begin
                    norm  = sum[27:1] | {26'b0, sum[0]};
                    e_res = exp_r + 10'sd1;
                end else begin
                    lz    = lzc27(sum[26:0]);
                    norm  = sum[26:0] << lz;
                    e_res = exp_r - $signed({5'b0, lz});
                end
                frac = norm[25:3];
            end
        endcase
        if (add_zero)                 norm_res = 32'h0;
        else if (e_res < 10'sd1)      norm_res = {sign_r, 31'b0};
        else if (e_res > 10'sd254)    norm_res = {sign_r, MAX_MAG};
        else                          norm_res = {sign_r, e_res[7:0], frac};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sign_r       <= 1'b0;
            eff_sub      <= 1'b0;
            exp_r        <= '0;
            man_big      <= '0;
            man_small    <= '0;
            prod         <= '0;
            rem          <= '0;
            quo          <= '0;
            cnt          <= '0;
            FPUResult    <= '0;
            flag_invalid <= 1'b0;
            flag_divzero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= FPUControl;
                        a_q   <= SrcA;
                        b_q   <= SrcB;
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    cnt <= '0;
                    if (spec_hit) begin
                        FPUResult    <= spec_res;
                        flag_invalid <= spec_nv;
                        flag_divzero <= spec_dz;
                        state        <= S_DONE;
                    end else if (op_q == FPU_MUL) begin
                        prod   <= {24'b0, ma};
                        exp_r  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
                        sign_r <= sgn_md;
                        state  <= S_MUL;
                    end else if (op_q == FPU_DIV) begin
                        rem    <= {1'b0, ma};
                        quo    <= '0;
                        exp_r  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
                        sign_r <= sgn_md;
                        state  <= S_DIV;
                    end else begin
                        state  <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    man_big   <= {(a_big ? ma : mb), 3'b000};
                    man_small <= small_sh | {26'b0, small_stk};
                    exp_r     <= $signed({2'b00, (a_big ? ea : eb)});
                    sign_r    <= a_big ? sa : sb_eff;
                    eff_sub   <= sa ^ sb_eff;
                    state     <= S_NORM;
                end
                S_MUL: begin
                    prod <= {mul_sum, prod[23:1]};
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd23) state <= S_NORM;
                end
                S_DIV: begin
                    rem  <= {div_diff[23:0], 1'b0};
                    quo  <= {quo[23:0], div_ge};
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd24) state <= S_NORM;
                end
                S_NORM: begin
                    FPUResult    <= norm_res;
                    flag_invalid <= 1'b0;
                    flag_divzero <= 1'b0;
                    state        <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_iter_exec.sv
// Self-checking bench for fpu_iter_exec: directed vector table, randomised ops vs a real-arithmetic model.
// Latency: checks done cycle per operation class.
// Backpressure: exercises dropped starts while busy/DONE and reset abort.
module tb_fpu_iter_exec;
    import fpu_defs::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  FPUControl = 3'b000;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        busy, done, flag_invalid, flag_divzero;
    logic [31:0] FPUResult;

    int tests = 0;
    int fails = 0;

    fpu_iter_exec dut (
        .CLK(CLK), .RST(RST), .start(start), .FPUControl(FPUControl),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
        .FPUResult(FPUResult), .flag_invalid(flag_invalid), .flag_divzero(flag_divzero)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        nv;
        logic        dz;
        logic [5:0]  lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Real-valued reference: single bits <-> double, RTZ truncation, FTZ, saturation.
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e11;
        e11 = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e11, f[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (e < 1)   return {d[63], 31'b0};
        if (e > 254) return {d[63], 31'h7F7F_FFFF};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        real r;
        case (op)
            FPU_ADD: r = f2r(a) + f2r(b);
            FPU_SUB: r = f2r(a) - f2r(b);
            FPU_MUL: r = f2r(a) * f2r(b);
            default: r = f2r(a) / f2r(b);
        endcase
        return r2f(r);
    endfunction

    // Add/sub exponents stay within 28 of each other so the double sum is exact.
    function automatic logic [31:0] rnd_norm(input logic [2:0] op);
        logic [7:0] e;
        if (op == FPU_ADD || op == FPU_SUB) e = 8'($urandom_range(112, 140));
        else                                e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic nv, output logic dz,
                         output int lat, output logic busy_ok, output logic hold_ok,
                         output logic idle_ok);
        logic [31:0] prev;
        logic        prev_nv, prev_dz;
        @(negedge CLK);
        start = 1'b1; FPUControl = op; SrcA = a; SrcB = b;
        prev = FPUResult; prev_nv = flag_invalid; prev_dz = flag_divzero;
        @(posedge CLK); #1;
        // Operands must be latched: scramble the inputs after acceptance.
        start = 1'b0; FPUControl = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
        lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            if (FPUResult !== prev || flag_invalid !== prev_nv || flag_divzero !== prev_dz) hold_ok = 1'b0;
            @(posedge CLK); #1;
        end
        res = FPUResult; nv = flag_invalid; dz = flag_divzero;
        @(posedge CLK); #1;
        idle_ok = !busy && !done && (FPUResult === res);
    endtask

    initial begin
        logic [31:0] res, a, b, expv;
        logic        nv, dz, bok, hok, iok;
        logic [2:0]  op;
        int          lat, explat, done_cnt, done_at;

        vecs.push_back(vec_t'{FPU_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 6'd4});
        vecs.push_back(vec_t'{FPU_MUL, 32'h40400000, 32'h3F000000, 32'h3FC00000, 1'b0, 1'b0, 6'd27});
        vecs.push_back(vec_t'{FPU_MUL, 32'h7F7FFFFF, 32'h40000000, 32'h7F7FFFFF, 1'b0, 1'b0, 6'd27});
        vecs.push_back(vec_t'{FPU_DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, 6'd28});
        vecs.push_back(vec_t'{FPU_DIV, 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1, 6'd2});
        vecs.push_back(vec_t'{FPU_SUB, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0, 6'd2});
        vecs.push_back(vec_t'{3'b111,  32'h3F800000, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0, 6'd2});
        vecs.push_back(vec_t'{FPU_SUB, 32'h3F800000, 32'h00800000, 32'h3F7FFFFF, 1'b0, 1'b0, 6'd4});
        vecs.push_back(vec_t'{FPU_ADD, 32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 1'b0, 6'd4});
        vecs.push_back(vec_t'{FPU_MUL, 32'h00000000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0, 6'd2});
        vecs.push_back(vec_t'{FPU_DIV, 32'h00000000, 32'h80000000, 32'h7FC00000, 1'b1, 1'b0, 6'd2});
        vecs.push_back(vec_t'{FPU_DIV, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1, 1'b0, 6'd2});
        vecs.push_back(vec_t'{FPU_ADD, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0, 6'd2});
        vecs.push_back(vec_t'{FPU_MUL, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b0, 6'd27});
        vecs.push_back(vec_t'{FPU_MUL, 32'hC0000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 6'd2});
        vecs.push_back(vec_t'{FPU_ADD, 32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 6'd2});
        vecs.push_back(vec_t'{FPU_DIV, 32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 6'd2});
        vecs.push_back(vec_t'{FPU_ADD, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 6'd2});
        vecs.push_back(vec_t'{FPU_SUB, 32'h7F800000, 32'hFF800000, 32'h7F800000, 1'b0, 1'b0, 6'd2});
        vecs.push_back(vec_t'{FPU_ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 6'd4});
        vecs.push_back(vec_t'{FPU_SUB, 32'h40000000, 32'h3FFFFFFF, 32'h34000000, 1'b0, 1'b0, 6'd4});
        vecs.push_back(vec_t'{FPU_DIV, 32'h40C00000, 32'h40400000, 32'h40000000, 1'b0, 1'b0, 6'd28});

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", FPUResult, 32'h0);
        chk("reset nv", 32'(flag_invalid), 32'd0);
        chk("reset dz", 32'(flag_divzero), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Directed vector table
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, nv, dz, lat, bok, hok, iok);
            chk($sformatf("vec%0d result", i), res, vecs[i].res);
            chk($sformatf("vec%0d nv", i), 32'(nv), 32'(vecs[i].nv));
            chk($sformatf("vec%0d dz", i), 32'(dz), 32'(vecs[i].dz));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d busy", i), 32'(bok), 32'd1);
            chk($sformatf("vec%0d hold", i), 32'(hok), 32'd1);
            chk($sformatf("vec%0d idle_after", i), 32'(iok), 32'd1);
        end

        // Starts during busy (cycle 5) and during DONE (cycle 28) are dropped.
        @(negedge CLK);
        start = 1'b1; FPUControl = FPU_DIV; SrcA = 32'h3F800000; SrcB = 32'h40400000;
        @(posedge CLK); #1;
        start = 1'b0;
        done_cnt = 0; done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            @(negedge CLK);
            start = (c == 5 || c == 28);
            FPUControl = FPU_ADD; SrcA = 32'h40000000; SrcB = 32'h40000000;
            @(posedge CLK); #1;
        end
        start = 1'b0;
        chk("ignored_start done count", 32'(done_cnt), 32'd1);
        chk("ignored_start done cycle", 32'(done_at), 32'd28);
        chk("ignored_start result", FPUResult, 32'h3EAAAAAA);

        // Leave NV set, then abort a div with reset at cycle 10.
        do_op(3'b110, 32'h3F800000, 32'h3F800000, res, nv, dz, lat, bok, hok, iok);
        chk("pre_abort nv", 32'(nv), 32'd1);
        @(negedge CLK);
        start = 1'b1; FPUControl = FPU_DIV; SrcA = 32'h3F800000; SrcB = 32'h40400000;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        chk("abort busy before reset", 32'(busy), 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort result", FPUResult, 32'h0);
        chk("abort nv", 32'(flag_invalid), 32'd0);
        chk("abort dz", 32'(flag_divzero), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            if (done) done_cnt++;
        end
        chk("abort no done", 32'(done_cnt), 32'd0);

        do_op(FPU_ADD, 32'h3F800000, 32'h40000000, res, nv, dz, lat, bok, hok, iok);
        chk("post_abort result", res, 32'h40400000);
        chk("post_abort latency", 32'(lat), 32'd4);

        // Randomised normal operands against the real-arithmetic model.
        for (int n = 0; n < 150; n++) begin
            op     = 3'($urandom_range(0, 3));
            a      = rnd_norm(op);
            b      = rnd_norm(op);
            expv   = ref_model(op, a, b);
            explat = (op == FPU_MUL) ? 27 : (op == FPU_DIV) ? 28 : 4;
            do_op(op, a, b, res, nv, dz, lat, bok, hok, iok);
            chk($sformatf("rnd%0d op%0d %h,%h result", n, op, a, b), res, expv);
            chk($sformatf("rnd%0d latency", n), 32'(lat), 32'(explat));
            chk($sformatf("rnd%0d flags", n), {30'b0, nv, dz}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
